bram_fifo_ctrl_72: RTL and testbench



---
 rtl/bram_fifo_ctrl_72_pkg.sv | 18 +
 rtl/bram_fifo_ctrl_72_if.sv | 22 ++
 rtl/bram_fifo_ctrl_72_skid.sv | 56 +++++
 rtl/bram_fifo_ctrl_72.sv | 88 ++++++++
 tb/tb_bram_fifo_ctrl_72.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bram_fifo_ctrl_72_pkg.sv
// Shared constants and types for the 256x72 block-RAM FIFO controller.
// The optional watermark output is enabled by the macro BRAM_FIFO_WATERMARK_EN.
package bram_fifo_ctrl_72_pkg;
   localparam int FIFO_DEPTH = 256;
   localparam int FIFO_AW    = 8;
   localparam int FIFO_DW    = 72;
   localparam int FIFO_CW    = 9;
   localparam int OB_CW      = 2;

   typedef logic [FIFO_DW-1:0] word_t;

   // One RAM operation per cycle, chosen by the arbiter in the top.
   typedef enum logic [1:0] {
      OP_IDLE,
      OP_WRITE,
      OP_READ
   } ram_op_t;
endpackage

// File: rtl/bram_fifo_ctrl_72_if.sv
// Push and pop valid/ready streams of the block-RAM FIFO controller.
// master = producer/consumer side, slave = the FIFO.
interface bram_fifo_ctrl_72_if;
   import bram_fifo_ctrl_72_pkg::*;

   logic  push_valid;
   word_t push_data;
   logic  push_ready;
   logic  pop_valid;
   word_t pop_data;
   logic  pop_ready;

   modport master (
      output push_valid, push_data, pop_ready,
      input  push_ready, pop_valid, pop_data
   );

   modport slave (
      input  push_valid, push_data, pop_ready,
      output push_ready, pop_valid, pop_data
   );
endinterface

// File: rtl/bram_fifo_ctrl_72_skid.sv
// Two-entry in-order output buffer (bram_fifo_skid) behind the block RAM.
// Entry e0 is always the head; a load and a pop may share a cycle.
module bram_fifo_skid
   import bram_fifo_ctrl_72_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  word_t            load_data,
   input  logic             pop,
   output logic             valid,
   output word_t            data,
   output logic [OB_CW-1:0] count
);

   word_t e0, e1;
   logic  take;

   assign valid = (count != '0);
   assign data  = e0;
   assign take  = pop & valid;

   // NOTE: non-blocking assignments here so every register samples the
   // pre-edge values of its neighbours (e0 <= e1 must see the old e1).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: only these two holding registers are reset so pop_data reads
         // zero in reset; the RAM array behind them is never cleared.
         e0    <= '0;
         e1    <= '0;
         count <= '0;
      end else begin
         case ({load, take})
            2'b10: begin
               if (count == '0) e0 <= load_data;
               else             e1 <= load_data;
               count <= count + OB_CW'(1);
            end
            2'b01: begin
               e0    <= e1;
               count <= count - OB_CW'(1);
            end
            2'b11: begin
               if (count == OB_CW'(1)) begin
                  e0 <= load_data;
               end else begin
                  e0 <= e1;
                  e1 <= load_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/bram_fifo_ctrl_72.sv
// First-word-fall-through FIFO built on a single-port 256x72 block RAM.
// Optional registered almost_full: define BRAM_FIFO_WATERMARK_EN.
module bram_fifo_ctrl_72
   import bram_fifo_ctrl_72_pkg::*;
#(
   parameter int AF_MARGIN = 8
) (
   input  logic               clk,
   input  logic               rst,
   bram_fifo_ctrl_72_if.slave bus,
   output logic               almost_full,
   output logic [FIFO_AW-1:0] ram_addr,
   output logic               ram_en,
   output logic               ram_we,
   output word_t              ram_wr,
   input  word_t              ram_rd
);

   logic [FIFO_AW-1:0] wptr, rptr;
   logic [FIFO_CW-1:0] ram_count, ram_count_nxt;
   logic               inflight;
   logic [OB_CW-1:0]   ob_count;
   ram_op_t            op;

   assign bus.push_ready = (ram_count != FIFO_CW'(FIFO_DEPTH));

   // Writes win so the capture side never stalls; reads only when the
   // skid buffer can absorb the word already in flight plus this one.
   always_comb begin
      // NOTE: default first so no path leaves op unassigned (no latch).
      op = OP_IDLE;
      if (rst && bus.push_valid && bus.push_ready)
         op = OP_WRITE;
      else if (rst && (ram_count != '0) && ((ob_count + OB_CW'(inflight)) < OB_CW'(2)))
         op = OP_READ;
   end

   always_comb begin
      ram_count_nxt = ram_count;
      case (op)
         OP_WRITE: ram_count_nxt = ram_count + FIFO_CW'(1);
         OP_READ:  ram_count_nxt = ram_count - FIFO_CW'(1);
         default:  ;
      endcase
   end

   assign ram_en   = (op != OP_IDLE);
   assign ram_we   = (op == OP_WRITE);
   assign ram_addr = (op == OP_READ) ? rptr : wptr;
   assign ram_wr   = bus.push_data;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr      <= '0;
         rptr      <= '0;
         ram_count <= '0;
         inflight  <= 1'b0;
      end else begin
         if (op == OP_WRITE) wptr <= wptr + FIFO_AW'(1);
         if (op == OP_READ)  rptr <= rptr + FIFO_AW'(1);
         ram_count <= ram_count_nxt;
         inflight  <= (op == OP_READ);
      end
   end

   bram_fifo_skid u_skid (
      .clk       (clk),
      .rst       (rst),
      .load      (inflight),
      .load_data (ram_rd),
      .pop       (bus.pop_ready),
      .valid     (bus.pop_valid),
      .data      (bus.pop_data),
      .count     (ob_count)
   );

`ifdef BRAM_FIFO_WATERMARK_EN
   localparam logic [FIFO_CW-1:0] AF_LEVEL = FIFO_CW'(FIFO_DEPTH - AF_MARGIN);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) almost_full <= 1'b0;
      else      almost_full <= (ram_count_nxt >= AF_LEVEL);
   end
`else
   assign almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_bram_fifo_ctrl_72.sv
// Self-checking bench for bram_fifo_ctrl_72 with a behavioural 256x72 RAM.
// Checks almost_full against ram occupancy when BRAM_FIFO_WATERMARK_EN is defined.
module tb_bram_fifo_ctrl_72;
   import bram_fifo_ctrl_72_pkg::*;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               almost_full;
   logic [FIFO_AW-1:0] ram_addr;
   logic               ram_en;
   logic               ram_we;
   word_t              ram_wr;
   word_t              ram_rd;
   word_t              mem [FIFO_DEPTH];

   int checks   = 0;
   int failures = 0;

   bram_fifo_ctrl_72_if bus ();

   bram_fifo_ctrl_72 #(.AF_MARGIN(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .almost_full (almost_full),
      .ram_addr    (ram_addr),
      .ram_en      (ram_en),
      .ram_we      (ram_we),
      .ram_wr      (ram_wr),
      .ram_rd      (ram_rd)
   );

   always #5 clk = ~clk;

   // Single-port synchronous RAM, read data one cycle after issue, no reset.
   always @(posedge clk) begin
      if (ram_en && ram_we)  mem[ram_addr] <= ram_wr;
      else if (ram_en)       ram_rd <= mem[ram_addr];
   end

   typedef struct {
      logic  push_valid;
      word_t push_data;
      logic  pop_ready;
      logic  exp_push_ready;
      logic  exp_pop_valid;
      logic  exp_ram_en;
      logic  exp_ram_we;
      logic [7:0] exp_ram_addr;
      logic  chk_data;
      word_t exp_pop_data;
   } vec_t;

   vec_t vecs [14];

   function automatic vec_t mk(logic pv, word_t pd, logic pr, logic e_prdy, logic e_pv,
                               logic e_en, logic e_we, logic [7:0] e_addr,
                               logic c_d, word_t e_d);
      vec_t v;
      v.push_valid     = pv;
      v.push_data      = pd;
      v.pop_ready      = pr;
      v.exp_push_ready = e_prdy;
      v.exp_pop_valid  = e_pv;
      v.exp_ram_en     = e_en;
      v.exp_ram_we     = e_we;
      v.exp_ram_addr   = e_addr;
      v.chk_data       = c_d;
      v.exp_pop_data   = e_d;
      return v;
   endfunction

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic exp_af(input int ram_words);
`ifdef BRAM_FIFO_WATERMARK_EN
      return (ram_words >= FIFO_DEPTH - 8);
`else
      return 1'b0;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pushes n words base..base+n-1, one per cycle; ram_before tracks RAM occupancy.
   task automatic push_burst(input int n, input int base, input logic pr,
                             input bit no_pop, input int cnt0, input string tag);
      for (int i = 0; i < n; i++) begin
         bus.push_valid = 1'b1;
         bus.push_data  = word_t'(base + i);
         bus.pop_ready  = pr;
         @(negedge clk);
         check($sformatf("%s push_ready[%0d]", tag, i), 72'(bus.push_ready), 72'(1));
         if (no_pop) check($sformatf("%s pop_valid[%0d]", tag, i), 72'(bus.pop_valid), 72'(0));
         check($sformatf("%s almost_full[%0d]", tag, i), 72'(almost_full), 72'(exp_af(cnt0 + i)));
         tick();
      end
      bus.push_valid = 1'b0;
   endtask

   task automatic drain(input int n, input int base, input string tag);
      int got = 0;
      int cyc = 0;
      bus.push_valid = 1'b0;
      bus.pop_ready  = 1'b1;
      while (got < n && cyc < 4000) begin
         @(negedge clk);
         if (bus.pop_valid) begin
            check($sformatf("%s data[%0d]", tag, got), bus.pop_data, word_t'(base + got));
            got++;
         end
         tick();
         cyc++;
      end
      check($sformatf("%s count", tag), 72'(got), 72'(n));
      @(negedge clk);
      check($sformatf("%s empty", tag), 72'(bus.pop_valid), 72'(0));
      check($sformatf("%s af_low", tag), 72'(almost_full), 72'(0));
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      word_t d_single, d_x, d_y;
      word_t sb [$];
      int sent, recv, cyc;
      logic got_d;

      d_single = 72'h12_3456789A_BCDEF012;
      d_x      = 72'hAA_0000_1111_2222_3333;
      d_y      = 72'h55_4444_5555_6666_7777;

      //            pv  data      pr  prdy popv en  we  addr  chk  data
      vecs[0]  = mk(1, d_single,  1,  1,   0,   1,  1,  8'd0, 0,   '0);
      vecs[1]  = mk(0, '0,        1,  1,   0,   1,  0,  8'd0, 0,   '0);
      vecs[2]  = mk(0, '0,        1,  1,   0,   0,  0,  8'd0, 0,   '0);
      vecs[3]  = mk(0, '0,        1,  1,   1,   0,  0,  8'd0, 1,   d_single);
      vecs[4]  = mk(0, '0,        1,  1,   0,   0,  0,  8'd0, 0,   '0);
      vecs[5]  = mk(1, d_x,       0,  1,   0,   1,  1,  8'd1, 0,   '0);
      vecs[6]  = mk(1, d_y,       0,  1,   0,   1,  1,  8'd2, 0,   '0);
      vecs[7]  = mk(0, '0,        0,  1,   0,   1,  0,  8'd1, 0,   '0);
      vecs[8]  = mk(0, '0,        0,  1,   0,   1,  0,  8'd2, 0,   '0);
      vecs[9]  = mk(0, '0,        0,  1,   1,   0,  0,  8'd0, 1,   d_x);
      vecs[10] = mk(0, '0,        0,  1,   1,   0,  0,  8'd0, 1,   d_x);
      vecs[11] = mk(0, '0,        1,  1,   1,   0,  0,  8'd0, 1,   d_x);
      vecs[12] = mk(0, '0,        1,  1,   1,   0,  0,  8'd0, 1,   d_y);
      vecs[13] = mk(0, '0,        1,  1,   0,   0,  0,  8'd0, 0,   '0);

      bus.push_valid = 1'b0;
      bus.push_data  = '0;
      bus.pop_ready  = 1'b0;

      // Reset values
      #12;
      check("rst pop_valid",   72'(bus.pop_valid),  72'(0));
      check("rst ram_en",      72'(ram_en),         72'(0));
      check("rst ram_we",      72'(ram_we),         72'(0));
      check("rst almost_full", 72'(almost_full),    72'(0));
      check("rst push_ready",  72'(bus.push_ready), 72'(1));
      check("rst pop_data",    bus.pop_data,        72'(0));
      @(negedge clk);
      rst = 1'b1;
      tick();

      // Table: single-push latency, then two words held and released
      for (int i = 0; i < 14; i++) begin
         bus.push_valid = vecs[i].push_valid;
         bus.push_data  = vecs[i].push_data;
         bus.pop_ready  = vecs[i].pop_ready;
         @(negedge clk);
         check($sformatf("v%0d push_ready", i), 72'(bus.push_ready), 72'(vecs[i].exp_push_ready));
         check($sformatf("v%0d pop_valid", i),  72'(bus.pop_valid),  72'(vecs[i].exp_pop_valid));
         check($sformatf("v%0d ram_en", i),     72'(ram_en),         72'(vecs[i].exp_ram_en));
         check($sformatf("v%0d ram_we", i),     72'(ram_we),         72'(vecs[i].exp_ram_we));
         check($sformatf("v%0d almost_full", i), 72'(almost_full),   72'(0));
         if (vecs[i].exp_ram_en)
            check($sformatf("v%0d ram_addr", i), 72'(ram_addr), 72'(vecs[i].exp_ram_addr));
         if (vecs[i].chk_data)
            check($sformatf("v%0d pop_data", i), bus.pop_data, vecs[i].exp_pop_data);
         tick();
      end

      // Fill the RAM, let reads top up the skid buffer, then fill to 258
      push_burst(256, 0, 1'b0, 1'b1, 0, "fill");
      @(negedge clk);
      check("fill full push_ready", 72'(bus.push_ready), 72'(0));
      check("fill full af",         72'(almost_full),    72'(exp_af(256)));
      tick();
      repeat (4) tick();
      @(negedge clk);
      check("fill skid pop_valid",  72'(bus.pop_valid),  72'(1));
      check("fill skid pop_data",   bus.pop_data,        72'(0));
      check("fill skid push_ready", 72'(bus.push_ready), 72'(1));
      tick();
      push_burst(2, 256, 1'b0, 1'b0, 254, "top");
      @(negedge clk);
      check("cap258 push_ready", 72'(bus.push_ready), 72'(0));
      tick();
      drain(258, 0, "drain258");

      // Continuous push and pop: writes starve reads until full
      push_burst(256, 1000, 1'b1, 1'b1, 0, "sim");
      @(negedge clk);
      check("sim full push_ready", 72'(bus.push_ready), 72'(0));
      tick();
      drain(256, 1000, "simdrain");

      // Pointer wrap with random handshakes against a scoreboard
      sent = 0;
      recv = 0;
      cyc  = 0;
      while (recv < 600 && cyc < 20000) begin
         bus.push_valid = (sent < 600) && ($urandom_range(0, 3) != 0);
         bus.push_data  = word_t'(5000 + sent);
         bus.pop_ready  = ($urandom_range(0, 1) == 1);
         @(negedge clk);
         if (bus.pop_valid && bus.pop_ready) begin
            if (sb.size() == 0) begin
               check($sformatf("wrap spurious[%0d]", recv), bus.pop_data, 72'hX);
            end else begin
               check($sformatf("wrap data[%0d]", recv), bus.pop_data, sb.pop_front());
            end
            recv++;
         end
         if (bus.push_valid && bus.push_ready) begin
            sb.push_back(bus.push_data);
            sent++;
         end
         tick();
         cyc++;
      end
      check("wrap received", 72'(recv), 72'(600));
      check("wrap leftover", 72'(sb.size()), 72'(0));
      bus.push_valid = 1'b0;
      bus.pop_ready  = 1'b0;
      repeat (2) tick();

      // Reset pulse with a read in flight and a word in the skid buffer
      for (int i = 0; i < 3; i++) begin
         bus.push_valid = 1'b1;
         bus.push_data  = word_t'(72'hA0 + i);
         tick();
      end
      bus.push_valid = 1'b0;
      tick();
      tick();
      check("prerst pop_valid", 72'(bus.pop_valid), 72'(1));
      check("prerst pop_data",  bus.pop_data,       72'hA0);
      rst = 1'b0;
      #1;
      check("midrst pop_valid",  72'(bus.pop_valid),  72'(0));
      check("midrst push_ready", 72'(bus.push_ready), 72'(1));
      check("midrst ram_en",     72'(ram_en),         72'(0));
      check("midrst pop_data",   bus.pop_data,        72'(0));
      @(negedge clk);
      rst = 1'b1;
      tick();
      bus.push_valid = 1'b1;
      bus.push_data  = 72'hD00D;
      bus.pop_ready  = 1'b1;
      tick();
      bus.push_valid = 1'b0;
      got_d = 1'b0;
      for (int i = 0; i < 10 && !got_d; i++) begin
         @(negedge clk);
         if (bus.pop_valid) begin
            check("postrst first word", bus.pop_data, 72'hD00D);
            check("postrst latency", 72'(i), 72'(2));
            got_d = 1'b1;
         end
         tick();
      end
      check("postrst word seen", 72'(got_d), 72'(1));
      @(negedge clk);
      check("postrst empty", 72'(bus.pop_valid), 72'(0));
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
